lottery_input: RTL and testbench
================================

LOTTERY_INPUT -- requirements
Module: lottery_input

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable clock cycles needed to accept a key level change (range 1..65535).
REQ-002 Port: clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-004 Port: sw  input  4  raw digit switches, asynchronous to clk.
REQ-005 Port: key_insert  input  1  raw insert push-button, active-high, asynchronous, bouncing.
REQ-006 Port: key_finish  input  1  raw finish push-button, active-high, asynchronous, bouncing.
REQ-007 Port: num  output  4  registered digit presented to the downstream game FSM.
REQ-008 Port: insert  output  1  one-cycle pulse; num is valid while insert is high.
REQ-009 Port: finish  output  1  one-cycle pulse requesting game evaluation.
REQ-010 Port: count  output  3  digits accepted in the current ticket (0..5).
REQ-011 Port: err  output  1  one-cycle pulse on a rejected key press.

Function
REQ-012 sw, key_insert and key_finish SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Each key SHALL have an independent debouncer: a debounced level and a counter; counter clears when synchronized level equals debounced level, otherwise increments; debounced level toggles and counter clears when the counter reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-014 A debounced 0->1 transition SHALL create one press event; 1->0 transitions and held keys SHALL create no events.
REQ-015 Press-event latency: a raw key held stable high SHALL produce its output pulse exactly 2+DEBOUNCE_CYCLES+1 rising edges after the first edge sampling it high.
REQ-016 Bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce no event.
REQ-017 Control FSM states: COLLECT (count 0..4), FULL (count 5). Reset state COLLECT, count 0.
REQ-018 Insert event in COLLECT with synchronized sw <= 9: insert=1 for one cycle, num<=sw in the same edge, count+1; count reaching 5 enters FULL.
REQ-019 Insert event in COLLECT with sw >= 10: err=1 for one cycle; num, count, state unchanged; no insert pulse.
REQ-020 Insert event in FULL: err=1 one cycle; no insert pulse; nothing else changes.
REQ-021 Finish event in FULL: finish=1 one cycle, count<=0, state<=COLLECT; num holds last value.
REQ-022 Finish event in COLLECT: err=1 one cycle; no finish pulse; count unchanged.
REQ-023 Insert and finish events in the same cycle: finish rules apply (REQ-021/022), insert event discarded; err asserted at most one cycle.
REQ-024 insert and finish SHALL never be high in the same cycle; each pulse is exactly one cycle wide.
REQ-025 num SHALL only change on an accepted insert; it always holds a value 0..9.

Reset
REQ-026 While reset=1: num=0, insert=0, finish=0, err=0, count=0, state COLLECT, all debounce counters and levels 0, synchronizer flops 0.
REQ-027 Reset mid-debounce or mid-ticket SHALL discard partial state; a key still held high when reset releases SHALL produce one event after full debounce latency.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-029 N=4; sw=5, key_insert held high from cycle 10 -> insert=1, num=5 at cycle 17 only, count=1.
REQ-030 Insert 5,0,9,6,7 then key_finish -> five insert pulses with num 5,0,9,6,7, count 1..5, then one finish pulse, count=0.
REQ-031 key_insert toggling every 2 cycles for 20 cycles, then low -> no insert, no err.
REQ-032 sw=12 with insert press -> err one cycle, no insert, count unchanged; finish press at count=3 -> err, no finish.
REQ-033 Count=5, sixth insert press -> err; simultaneous insert+finish press at count=5 -> finish only, count=0.
REQ-034 reset=1 for one cycle at count=3 mid-debounce -> all outputs 0 next cycle; following ticket behaves as REQ-030.

Source files
------------

// File: rtl/lottery_input.sv
`default_nettype none
// ============================================================================
// lottery_input : synchronizes and debounces the ticket keys, collects 5 digits
// Revision 1.0
// ============================================================================
module lottery_input #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       key_insert,
    input  logic       key_finish,
    output logic [3:0] num,
    output logic       insert,
    output logic       finish,
    output logic [2:0] count,
    output logic       err
);

    localparam int          KEYS       = 2;
    localparam int          KEY_INS    = 0;
    localparam int          KEY_FIN    = 1;
    localparam logic [15:0] CNT_MAX    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]  COUNT_FULL = 3'd5;
    localparam logic [3:0]  DIGIT_MAX  = 4'd9;

    localparam logic [0:0]  ST_COLLECT = 1'b0;
    localparam logic [0:0]  ST_FULL    = 1'b1;

    logic [3:0]      sw_meta_q;
    logic [3:0]      sw_sync_q;
    logic [KEYS-1:0] key_meta_q;
    logic [KEYS-1:0] key_sync_q;
    logic [KEYS-1:0] keys_raw;
    logic [KEYS-1:0] press_ev;

    assign keys_raw = {key_finish, key_insert};

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= '0;
            key_sync_q <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= keys_raw;
            key_sync_q <= key_meta_q;
        end
    end

    // The press pulse is taken from the registered level so that every key
    // event reaches the outputs a fixed 2 + DEBOUNCE_CYCLES + 1 edges late.
    generate
        for (genvar k = 0; k < KEYS; k++) begin : g_debounce
            logic [15:0] cnt_q;
            logic        level_q;
            logic        level_prev_q;
            logic        press_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q        <= '0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    press_q      <= 1'b0;
                end else begin
                    level_prev_q <= level_q;
                    press_q      <= level_q & ~level_prev_q;
                    if (key_sync_q[k] == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        level_q <= ~level_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
            end

            assign press_ev[k] = press_q;
        end
    endgenerate

    logic [0:0] state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [3:0] num_q, num_d;
    logic       insert_q, insert_d;
    logic       finish_q, finish_d;
    logic       err_q, err_d;

    // A finish event takes priority; a coincident insert event is dropped.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        num_d    = num_q;
        insert_d = 1'b0;
        finish_d = 1'b0;
        err_d    = 1'b0;
        if (press_ev[KEY_FIN]) begin
            if (state_q == ST_FULL) begin
                finish_d = 1'b1;
                count_d  = '0;
                state_d  = ST_COLLECT;
            end else begin
                err_d = 1'b1;
            end
        end else if (press_ev[KEY_INS]) begin
            if (state_q == ST_FULL || sw_sync_q > DIGIT_MAX) begin
                err_d = 1'b1;
            end else begin
                insert_d = 1'b1;
                num_d    = sw_sync_q;
                count_d  = count_q + 3'd1;
                if (count_q + 3'd1 == COUNT_FULL) begin
                    state_d = ST_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_COLLECT;
            count_q  <= '0;
            num_q    <= '0;
            insert_q <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            num_q    <= num_d;
            insert_q <= insert_d;
            finish_q <= finish_d;
            err_q    <= err_d;
        end
    end

    assign num    = num_q;
    assign insert = insert_q;
    assign finish = finish_q;
    assign count  = count_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lottery_input.sv
`default_nettype none
// ============================================================================
// tb_lottery_input : scoreboard bench with a ticket-level reference model
// Revision 1.0
// ============================================================================
module tb_lottery_input;

    localparam int N       = 4;
    localparam int LATENCY = 2 + N + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'd0;
    logic       key_insert = 1'b0;
    logic       key_finish = 1'b0;
    logic [3:0] num;
    logic       insert;
    logic       finish;
    logic [2:0] count;
    logic       err;

    lottery_input #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .key_insert (key_insert),
        .key_finish (key_finish),
        .num        (num),
        .insert     (insert),
        .finish     (finish),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    // kind: 0 = insert pulse, 1 = finish pulse, 2 = err pulse
    typedef struct {
        int kind;
        int num;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_count = 0;
    int   m_num   = 0;
    int   mon_num = 0;
    int   mon_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            mon_num = 0;
            mon_cnt = 0;
        end else begin
            if (insert || finish || err) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: cycle %0d got ins=%b fin=%b err=%b, required no pulse",
                             cyc, insert, finish, err);
                end else begin
                    logic [2:0] want;
                    mon_e = sb.pop_front();
                    want = (mon_e.kind == 0) ? 3'b100 : (mon_e.kind == 1) ? 3'b010 : 3'b001;
                    if ({insert, finish, err} !== want || num !== 4'(mon_e.num) ||
                        count !== 3'(mon_e.cnt) || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL event: got ins/fin/err=%b num=%0d count=%0d cycle=%0d, required %b num=%0d count=%0d cycle=%0d",
                                 {insert, finish, err}, num, count, cyc, want, mon_e.num, mon_e.cnt, mon_e.cyc);
                    end
                    mon_num = mon_e.num;
                    mon_cnt = mon_e.cnt;
                end
            end
            n_tests++;
            if (num !== 4'(mon_num) || count !== 3'(mon_cnt)) begin
                n_fail++;
                $display("FAIL hold: cycle %0d got num=%0d count=%0d, required num=%0d count=%0d",
                         cyc, num, count, mon_num, mon_cnt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Ticket rules: finish wins over insert; 5 digits fill the ticket.
    task automatic push_exp(input bit ins, input bit fin, input int swv, input int t0);
        exp_t e;
        if (fin) begin
            if (m_count == 5) begin
                e.kind  = 1;
                m_count = 0;
            end else begin
                e.kind = 2;
            end
        end else if (ins) begin
            if (m_count == 5 || swv > 9) begin
                e.kind = 2;
            end else begin
                e.kind = 0;
                m_num  = swv;
                m_count++;
            end
        end
        e.num = m_num;
        e.cnt = m_count;
        e.cyc = t0 + LATENCY + 1;
        sb.push_back(e);
    endtask

    task automatic press(input bit ins, input bit fin, input int swv, input int nb);
        sw = 4'(swv);
        for (int b = 0; b < nb; b++) begin
            key_insert = ins;
            key_finish = fin;
            tick($urandom_range(1, N - 1));
            key_insert = 1'b0;
            key_finish = 1'b0;
            tick($urandom_range(1, 3));
        end
        key_insert = ins;
        key_finish = fin;
        push_exp(ins, fin, swv, cyc);
        tick(N + 8);
        key_insert = 1'b0;
        key_finish = 1'b0;
        tick(N + 8);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        chk("reset_num", int'(num), 0);
        chk("reset_insert", int'(insert), 0);
        chk("reset_finish", int'(finish), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_count", int'(count), 0);
        sb.delete();
        m_count = 0;
        m_num   = 0;
        reset   = 1'b0;
    endtask

    task automatic ticket(input int d0, input int d1, input int d2, input int d3, input int d4);
        press(1, 0, d0, 0);
        press(1, 0, d1, 0);
        press(1, 0, d2, 0);
        press(1, 0, d3, 0);
        press(1, 0, d4, 0);
        press(0, 1, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        do_reset(3);

        ticket(5, 0, 9, 6, 7);

        for (int i = 0; i < 5; i++) begin
            key_insert = 1'b1;
            tick(2);
            key_insert = 1'b0;
            tick(2);
        end
        tick(20);

        press(1, 0, 1, 0);
        press(1, 0, 2, 0);
        press(1, 0, 3, 0);
        press(1, 0, 12, 0);
        press(0, 1, 4, 0);
        press(1, 0, 4, 0);
        press(1, 0, 5, 0);
        press(1, 0, 8, 0);
        press(1, 1, 2, 0);

        press(1, 0, 1, 0);
        press(1, 0, 2, 0);
        press(1, 0, 3, 0);
        sw = 4'd5;
        key_insert = 1'b1;
        tick(3);
        do_reset(1);
        push_exp(1, 0, 5, cyc);
        tick(N + 8);
        key_insert = 1'b0;
        tick(N + 8);
        press(1, 0, 0, 0);
        press(1, 0, 9, 0);
        press(1, 0, 6, 0);
        press(1, 0, 7, 0);
        press(0, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      press(1, 0, $urandom_range(0, 15), $urandom_range(0, 3));
            else if (r < 8) press(0, 1, $urandom_range(0, 15), $urandom_range(0, 3));
            else            press(1, 1, $urandom_range(0, 15), $urandom_range(0, 3));
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        chk("drain_pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
